// File: rtl/ss_pc_16b_pkg.sv
// Shared datapath constants for the program counter and the control unit.
// No logic, so no latency.
// No flow control.
package ss_pc_16b_pkg;

    // Program counter width
    localparam int PC_W = 16;

    // Value the PC takes while reset is asserted
    localparam logic [PC_W-1:0] PC_RESET_VECTOR = 16'h0000;

    // Next-PC select encoding, shared with the control unit
    localparam logic PC_SRC_REL = 1'b0;
    localparam logic PC_SRC_ABS = 1'b1;

endpackage : ss_pc_16b_pkg

// File: rtl/ss_pc_next_16b.sv
// Next-PC select: relative path (pc + 1 + add) or absolute target b.
// Purely combinational, zero cycles.
// No flow control.
module ss_pc_next_16b
    import ss_pc_16b_pkg::*;
#(
    parameter int WIDTH = PC_W
) (
    input  logic [WIDTH-1:0] i_pc,
    input  logic [WIDTH-1:0] i_add,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_pc_src,
    output logic [WIDTH-1:0] o_next
);

    logic [WIDTH-1:0] w_rel;

    // The offset is two's complement, so a plain modulo-2^WIDTH sum handles
    // negative offsets; the carry out of the top bit is dropped.
    assign w_rel = i_pc + WIDTH'(1) + i_add;

    // Choose between the relative and absolute targets
    always_comb begin
        o_next = w_rel;
        if (i_pc_src == PC_SRC_ABS) begin
            o_next = i_b;
        end
    end

endmodule : ss_pc_next_16b

// File: rtl/ss_pc_16b.sv
// Program counter register with write enable and next-PC select.
// One cycle: inputs sampled on a rising edge of CLK show on pc right after it.
// No flow control; pc_write = 0 holds the current value.
module ss_pc_16b
    import ss_pc_16b_pkg::*;
#(
    parameter int               WIDTH        = PC_W,
    parameter logic [WIDTH-1:0] RESET_VECTOR = PC_RESET_VECTOR
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [WIDTH-1:0] add,
    input  logic [WIDTH-1:0] b,
    input  logic             pc_src,
    input  logic             pc_write,
    output logic [WIDTH-1:0] pc
);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_next;

    ss_pc_next_16b #(
        .WIDTH (WIDTH)
    ) u_next (
        .i_pc     (r_pc),
        .i_add    (add),
        .i_b      (b),
        .i_pc_src (pc_src),
        .o_next   (w_next)
    );

    // PC register: asynchronous active-low clear, load the selected value when enabled
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_pc <= RESET_VECTOR;
        end else if (pc_write) begin
            r_pc <= w_next;
        end
    end

    assign pc = r_pc;

endmodule : ss_pc_16b

// File: tb/tb_ss_pc_16b.sv
// Directed bench for ss_pc_16b with hand-computed expected PC values.
module tb_ss_pc_16b;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] add = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic        pc_src = 1'b0;
    logic        pc_write = 1'b0;
    logic [15:0] pc;

    int n_cmp = 0;
    int n_err = 0;

    ss_pc_16b dut (
        .CLK      (CLK),
        .reset    (reset),
        .add      (add),
        .b        (b),
        .pc_src   (pc_src),
        .pc_write (pc_write),
        .pc       (pc)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: pc=%h expected %h", tag, got, exp);
        end
    endtask

    // Drive inputs away from the edge, clock once, sample 1 ns after the edge
    task automatic step(input logic we, input logic src, input logic [15:0] a,
                        input logic [15:0] bb);
        pc_write = we;
        pc_src   = src;
        add      = a;
        b        = bb;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // Assert reset before the first edge
        #2 reset = 1'b0;
        #1 chk("reset_async", pc, 16'h0000);

        // Hold reset for ~100 ns with enabled writes of both kinds
        for (int i = 0; i < 10; i++) begin
            step(1'b1, i[0], 16'h0000, 16'd15);
            chk($sformatf("reset_hold%0d", i), pc, 16'h0000);
        end

        // Release reset, load 0x1234, then assert reset between edges
        reset = 1'b1;
        step(1'b1, 1'b1, 16'h0000, 16'h1234);
        chk("load_1234", pc, 16'h1234);
        #2 reset = 1'b0;
        #1 chk("reset_mid", pc, 16'h0000);
        step(1'b1, 1'b1, 16'h0000, 16'h1234);
        chk("reset_over_we", pc, 16'h0000);
        reset = 1'b1;

        // Writes disabled: pc holds
        step(1'b0, 1'b0, 16'h0000, 16'd15);
        chk("hold_rel", pc, 16'h0000);
        step(1'b0, 1'b1, 16'h0000, 16'd15);
        chk("hold_abs", pc, 16'h0000);

        // Increment then absolute jump
        step(1'b1, 1'b0, 16'h0000, 16'd15);
        chk("inc_first", pc, 16'h0001);
        step(1'b1, 1'b1, 16'h0000, 16'd15);
        chk("jump_15", pc, 16'd15);

        // Positive and negative relative offsets
        step(1'b1, 1'b0, 16'h0004, 16'd0);
        chk("rel_plus4", pc, 16'd20);
        step(1'b1, 1'b0, 16'hFFFD, 16'd0);
        chk("rel_minus3", pc, 16'd18);
        step(1'b1, 1'b1, 16'h0000, 16'd5);
        chk("jump_5", pc, 16'd5);
        step(1'b1, 1'b0, 16'hFFFE, 16'd0);
        chk("rel_minus2", pc, 16'd4);

        // Wrap past the top of the address space
        step(1'b1, 1'b1, 16'h0000, 16'hFFFF);
        chk("jump_ffff", pc, 16'hFFFF);
        step(1'b1, 1'b0, 16'h0000, 16'h0000);
        chk("wrap", pc, 16'h0000);

        // Write enable toggled 1,0,1; inputs changing during the hold are ignored
        step(1'b1, 1'b0, 16'h0000, 16'h0000);
        chk("we_seq1", pc, 16'h0001);
        step(1'b0, 1'b1, 16'h0100, 16'hABCD);
        chk("we_seq0", pc, 16'h0001);
        step(1'b1, 1'b0, 16'h0000, 16'h0000);
        chk("we_seq2", pc, 16'h0002);

        // Resume from the reset vector after a mid-run reset
        #2 reset = 1'b0;
        #1 chk("reset_again", pc, 16'h0000);
        reset = 1'b1;
        step(1'b1, 1'b0, 16'h0000, 16'h0000);
        chk("resume", pc, 16'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_ss_pc_16b

// File: doc/ss_pc_16b.md
Name: ss_pc_16b

Overview:
- 16-bit program counter register with a next-PC select stage for the single-cycle/multicycle datapath.
- Each enabled clock edge loads either the relative path (PC + 1 + `add` offset) or the absolute target `b`.
- The output `pc` drives instruction-memory addressing and the branch/jump adders upstream.

Parameters:
- WIDTH, 16, data width of PC, `add` and `b`.
- RESET_VECTOR, 16'h0000, value of `pc` while reset is asserted.

Ports:
- CLK  input  1  system clock; all updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted); forces `pc` to RESET_VECTOR immediately.
- add  input  16  signed two's-complement relative offset; 0 means plain sequential increment.
- b  input  16  absolute target address (jump/branch destination).
- pc_src  input  1  next-PC select: 0 = relative path, 1 = absolute `b`.
- pc_write  input  1  PC write enable; 1 = load the selected next value on the rising edge of CLK.
- pc  output  16  current program counter value, registered.

Behaviour:
- One clock (CLK). Reset is asynchronous and active-low: `reset` = 0 forces `pc` = RESET_VECTOR (0x0000) with no clock needed, and holds it while low. Deassertion (0→1) takes effect from the next rising edge; no synchronizer is inside this block.
- Next-value computation is purely combinational:
  - pc_src = 0: next = pc + 16'd1 + add, modulo 2^16. Carries out of bit 15 are discarded, so 0xFFFF + 1 + 0 = 0x0000.
  - pc_src = 1: next = b.
- Rising edge of CLK with reset = 1:
  - pc_write = 1: pc ← next.
  - pc_write = 0: pc holds its value; pc_src, add and b are ignored.
- Latency: one cycle. An input sampled at edge N is visible on `pc` immediately after edge N. No combinational path from any input to `pc`, except the asynchronous reset.
- Example: from pc = 0 with add = 0, one enabled edge with pc_src = 0 gives pc = 1. A following enabled edge with pc_src = 1 and b = 15 gives pc = 15.
- Simultaneous events:
  - Reset low overrides pc_write at any time.
  - Asserting reset mid-sequence clears `pc` at once; operation resumes from 0x0000 after deassertion.
- Negative offsets (add[15] = 1) wrap naturally, e.g. pc = 5, add = 0xFFFE (−2), pc_src = 0 → pc = 4.
- All inputs are treated as known. X on pc_write or pc_src is outside the legal operating range.
- No handshakes, no status outputs, no state beyond the 16-bit PC register.

Decomposition:
- Shared package (datapath-wide):
  - PC width constant (16).
  - RESET_VECTOR.
  - pc_src encoding constants PC_SRC_REL = 1'b0 and PC_SRC_ABS = 1'b1, reused by the control unit.
- One sub-module, ss_pc_next_16b: combinational adder (pc + 1 + add) plus 2:1 mux on pc_src.
- The top level holds only the enabled register with asynchronous active-low clear.

Test Plan:
- Hold reset = 0 for 100 ns, toggling inputs (add = 0, b = 15, both pc_src values, pc_write = 1) → pc stays 0x0000 throughout. Assert reset low while pc = 0x1234 between edges → pc = 0x0000 before the next edge.
- Release reset; pc_write = 0, pc_src cycled 0 then 1, b = 15, two edges → pc remains 0x0000.
- pc_write = 1, pc_src = 0, add = 0, one edge → pc = 1. Then pc_src = 1, b = 15, next edge → pc = 15.
- pc = 15, pc_src = 0, add = 0x0004 → pc = 20. Then add = 0xFFFD (−3) → pc = 18.
- Load b = 0xFFFF via pc_src = 1, then pc_src = 0, add = 0, one edge → pc wraps to 0x0000.
- pc_write toggled 1,0,1 with pc_src = 0, add = 0 over three edges → pc sequence 1, 1, 2.
